tff_toggle_driver: RTL and testbench
====================================

// Module: tff_toggle_driver
// PURPOSE
//  Drive side of a bank of T flip-flops/latches: accepts target level words and
//  emits the t pulses that move the external TFF bank to each target.
//  Keeps a shadow copy of the bank state, buffers words in a small FIFO, and
//  rate-limits toggles per cycle.
//  Sits between a level-based producer and any t/q toggle storage.
// PARAMETERS
//  W        8  width of target word / TFF bank
//  DEPTH    4  input FIFO entries (power of 2, >=2)
//  MAX_TOG  W  max t bits asserted in one cycle (1..W)
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  in_valid     in   1           target word present
//  in_ready     out  1           FIFO can accept (= !full)
//  in_data      in   W           target level word
//  t_out        out  W           registered toggle pulses to TFF bank
//  shadow_q     out  W           committed bank state
//  busy         out  1           state!=IDLE || fifo_count!=0
//  fifo_count   out  $clog2(DEPTH)+1  words buffered
//  q_fb         in   W           bank readback (TDRV_READBACK_CHECK_EN only)
//  err_mismatch out  1           sticky readback error (TDRV_READBACK_CHECK_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): t_out=0, shadow_q=0, FIFO empty, fifo_count=0,
//    in_ready=1, busy=0, state=IDLE, err_mismatch=0. Bank must also reset to 0.
//  - Push on in_valid&&in_ready. in_ready depends only on full; a push is
//    refused when full even if a pop happens in the same cycle. Push and pop
//    together when not full leave fifo_count unchanged.
//  - FSM IDLE: if fifo_count>0, pop head into target reg -> ISSUE. t_out=0.
//  - FSM ISSUE, each cycle: pending = target ^ shadow_q. Select the lowest-index
//    set bits of pending, up to MAX_TOG bits. t_out <= sel; shadow_q <= shadow_q^sel.
//    If pending==0: t_out <= 0. Then pop the next word if available (stay ISSUE),
//    else go to IDLE.
//  - t_out is a 1-cycle pulse per issue cycle. It is never held across cycles
//    unless new bits are selected.
//  - Latency, MAX_TOG=W, empty FIFO and IDLE: word pushed at edge k, popped at
//    edge k+1, t_out asserted after edge k+2. Bank q follows after edge k+3.
//  - A word equal to shadow_q costs one ISSUE cycle with t_out=0.
//  - Words needing n toggles take ceil(n/MAX_TOG) cycles (minimum 1).
//  - Shadow wraps by XOR only; no arithmetic.
//  - Reset mid-ISSUE: work in flight and buffered words are discarded.
//    Outputs return to reset values immediately.
// CONFIGURATION
//  TDRV_READBACK_CHECK_EN defined:
//    - q_fb and err_mismatch ports exist.
//    - shadow_d1 = shadow_q delayed 1 cycle.
//    - Each cycle out of reset, q_fb!=shadow_d1 sets err_mismatch; it stays set
//      until rst_n.
//  Not defined: no q_fb/err_mismatch ports, no checker logic.
//    Drive behaviour is identical.
// TESTING
//  1 Reset: rst_n=0 mid-run -> t_out=0, shadow_q=0, fifo_count=0, in_ready=1
//    at once.
//  2 W=8,MAX_TOG=8: push 0xA5 from 0x00 -> single t_out=0xA5 pulse at edge k+2,
//    shadow_q=0xA5. Push 0xA5 again -> t_out stays 0x00.
//  3 MAX_TOG=2: shadow 0x00, push 0x0F -> t_out 0x03 then 0x0C on consecutive
//    cycles; shadow_q=0x0F; busy drops after.
//  4 DEPTH=4,MAX_TOG=1: push 0xFF,0x00,0xFF,0x00,0x0F back-to-back -> in_ready
//    low while fifo_count=4, no word lost, t pulses count 8+8+8+8+4, final
//    shadow_q=0x0F.
//  5 Reset mid-ISSUE (0x00->0xFF, MAX_TOG=1, after 3 pulses) -> outputs cleared;
//    next push 0x01 -> t_out=0x01 only.
//  6 TDRV_READBACK_CHECK_EN: model TFF bank on t_out, force q_fb[3] inverted
//    one cycle -> err_mismatch=1 next edge, held until rst_n.

Source files
------------

// File: rtl/tff_toggle_driver.sv
// tff_toggle_driver: turns target level words into t pulses for an
// external T flip-flop bank, tracking the bank state in a shadow copy.
//
// Parameters:
//   W        width of target word / TFF bank
//   DEPTH    input FIFO entries (power of 2, >= 2)
//   MAX_TOG  max t bits asserted in one cycle (1..W)
//
// Ports:
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   target word present
//   in_ready     out  FIFO can accept (not full)
//   in_data      in   target level word
//   t_out        out  registered toggle pulses to the TFF bank
//   shadow_q     out  committed bank state
//   busy         out  FSM not idle or words still buffered
//   fifo_count   out  number of buffered words
//   q_fb         in   bank readback   (TDRV_READBACK_CHECK_EN only)
//   err_mismatch out  sticky readback error (TDRV_READBACK_CHECK_EN only)
//
// Optional feature macro: TDRV_READBACK_CHECK_EN enables the readback checker.

module tff_toggle_driver #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int MAX_TOG = W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    output logic [W-1:0]             t_out,
    output logic [W-1:0]             shadow_q,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef TDRV_READBACK_CHECK_EN
    ,
    input  logic [W-1:0]             q_fb,
    output logic                     err_mismatch
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(W + 1) + 1;
    localparam logic [CW-1:0] MAXT = CW'(MAX_TOG);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [W-1:0]  target;
    logic [W-1:0]  pending;
    logic [W-1:0]  sel;
    logic [CW-1:0] nsel;
    logic          done;
    logic          full;
    logic          push;
    logic          pop;
    logic [W-1:0]  head;

    assign full       = (count == FULL);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

    assign pending = target ^ shadow_q;
    // The current word is finished once this cycle's selection covers
    // every remaining pending bit; the next word is fetched in that cycle.
    assign done    = ((pending ^ sel) == '0);

    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = (count != '0);
            ISSUE:   pop = done && (count != '0);
            default: pop = 1'b0;
        endcase
    end

    // Lowest-index pending bits, capped at MAX_TOG per cycle.
    always_comb begin
        sel  = '0;
        nsel = '0;
        for (int i = 0; i < W; i++) begin
            if (pending[i] && (nsel < MAXT)) begin
                sel[i] = 1'b1;
                nsel   = nsel + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= '0;
            t_out    <= '0;
            shadow_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    t_out <= '0;
                    if (count != '0) begin
                        target <= head;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // sel is zero when pending is zero, so an already
                    // matching word costs one silent cycle.
                    t_out    <= sel;
                    shadow_q <= shadow_q ^ sel;
                    if (done) begin
                        if (count != '0) begin
                            target <= head;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    t_out <= '0;
                end
            endcase
        end
    end

`ifdef TDRV_READBACK_CHECK_EN
    // The bank toggles one edge after t_out is issued, while shadow_q
    // moves on the same edge as t_out; delaying shadow_q aligns them.
    logic [W-1:0] shadow_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_d1    <= '0;
            err_mismatch <= 1'b0;
        end else begin
            shadow_d1 <= shadow_q;
            if (q_fb != shadow_d1) begin
                err_mismatch <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tff_toggle_driver.sv
// tb_tff_toggle_driver: directed bench for tff_toggle_driver with
// MAX_TOG = 8, 2 and 1 instances sharing clock and reset.

module tb_tff_toggle_driver;

    logic       clk;
    logic       rst_n;

    logic       v8, v2, v1;
    logic [7:0] d8, d2, d1;
    logic       r8, r2, r1;
    logic [7:0] t8, t2, t1;
    logic [7:0] s8, s2, s1;
    logic       b8, b2, b1;
    logic [2:0] c8, c2, c1;

    int n_chk;
    int n_fail;
    int tog1;
    logic cnt_en;

`ifdef TDRV_READBACK_CHECK_EN
    logic [7:0] bank8, bank2, bank1;
    logic [7:0] fb8;
    logic       e8, e2, e1;
    logic       inj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank8 <= '0;
            bank2 <= '0;
            bank1 <= '0;
        end else begin
            bank8 <= bank8 ^ t8;
            bank2 <= bank2 ^ t2;
            bank1 <= bank1 ^ t1;
        end
    end

    assign fb8 = bank8 ^ (inj ? 8'h08 : 8'h00);
`endif

    tff_toggle_driver #(.W(8), .DEPTH(4), .MAX_TOG(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
        .in_data(d8), .t_out(t8), .shadow_q(s8), .busy(b8),
        .fifo_count(c8)
`ifdef TDRV_READBACK_CHECK_EN
        , .q_fb(fb8), .err_mismatch(e8)
`endif
    );

    tff_toggle_driver #(.W(8), .DEPTH(4), .MAX_TOG(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
        .in_data(d2), .t_out(t2), .shadow_q(s2), .busy(b2),
        .fifo_count(c2)
`ifdef TDRV_READBACK_CHECK_EN
        , .q_fb(bank2), .err_mismatch(e2)
`endif
    );

    tff_toggle_driver #(.W(8), .DEPTH(4), .MAX_TOG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_data(d1), .t_out(t1), .shadow_q(s1), .busy(b1),
        .fifo_count(c1)
`ifdef TDRV_READBACK_CHECK_EN
        , .q_fb(bank1), .err_mismatch(e1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cnt_en) tog1 += $countones(t1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words [5];
        int guard;
        words = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h0F};
        n_chk  = 0;
        n_fail = 0;
        tog1   = 0;
        cnt_en = 1'b0;
        rst_n  = 1'b0;
        v8 = 0; v2 = 0; v1 = 0;
        d8 = '0; d2 = '0; d1 = '0;
`ifdef TDRV_READBACK_CHECK_EN
        inj = 1'b0;
`endif
        #2;
        chk("rst_t_out",    32'(t8), 32'h00);
        chk("rst_shadow",   32'(s8), 32'h00);
        chk("rst_count",    32'(c8), 32'd0);
        chk("rst_ready",    32'(r8), 32'd1);
        chk("rst_busy",     32'(b8), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // MAX_TOG=8: 0x00 -> 0xA5 in one pulse at edge k+2
        v8 = 1; d8 = 8'hA5;
        tick();
        v8 = 0;
        chk("a5_count_k",   32'(c8), 32'd1);
        tick();
        chk("a5_t_k1",      32'(t8), 32'h00);
        chk("a5_busy_k1",   32'(b8), 32'd1);
        chk("a5_count_k1",  32'(c8), 32'd0);
        tick();
        chk("a5_t_k2",      32'(t8), 32'hA5);
        chk("a5_shadow_k2", 32'(s8), 32'hA5);
        chk("a5_busy_k2",   32'(b8), 32'd0);
        tick();
        chk("a5_t_k3",      32'(t8), 32'h00);

        // Same word again: silent issue cycle
        v8 = 1; d8 = 8'hA5;
        tick();
        v8 = 0;
        tick();
        tick();
        chk("a5b_t_k2",     32'(t8), 32'h00);
        chk("a5b_shadow",   32'(s8), 32'hA5);
        tick();
        chk("a5b_t_k3",     32'(t8), 32'h00);
        chk("a5b_busy",     32'(b8), 32'd0);

        // MAX_TOG=2: 0x0F split into 0x03 then 0x0C
        v2 = 1; d2 = 8'h0F;
        tick();
        v2 = 0;
        tick();
        tick();
        chk("m2_t_first",   32'(t2), 32'h03);
        chk("m2_sh_first",  32'(s2), 32'h03);
        tick();
        chk("m2_t_second",  32'(t2), 32'h0C);
        chk("m2_shadow",    32'(s2), 32'h0F);
        chk("m2_busy",      32'(b2), 32'd0);
        tick();
        chk("m2_t_after",   32'(t2), 32'h00);

        // MAX_TOG=1: back-to-back words fill the FIFO
        cnt_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v1 = 1; d1 = words[i];
            tick();
        end
        chk("m1_count_full", 32'(c1), 32'd4);
        chk("m1_ready_full", 32'(r1), 32'd0);
        d1 = 8'h55;
        tick();
        v1 = 0;
        chk("m1_refused",   32'(c1), 32'd4);
        guard = 0;
        while (b1 && guard < 200) begin
            tick();
            guard++;
        end
        chk("m1_drain_timeout", 32'(b1), 32'd0);
        tick();
        tick();
        cnt_en = 1'b0;
        chk("m1_toggles",   32'(tog1), 32'd36);
        chk("m1_shadow",    32'(s1), 32'h0F);
        chk("m1_t_idle",    32'(t1), 32'h00);

        // Reset mid-issue with a word still buffered
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        v1 = 1; d1 = 8'hFF;
        tick();
        d1 = 8'h33;
        tick();
        v1 = 0;
        tick();
        chk("rm_p1",        32'(t1), 32'h01);
        tick();
        chk("rm_p2",        32'(t1), 32'h02);
        tick();
        chk("rm_p3",        32'(t1), 32'h04);
        chk("rm_buffered",  32'(c1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_t_out",     32'(t1), 32'h00);
        chk("rm_shadow",    32'(s1), 32'h00);
        chk("rm_count",     32'(c1), 32'd0);
        chk("rm_ready",     32'(r1), 32'd1);
        chk("rm_busy",      32'(b1), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        v1 = 1; d1 = 8'h01;
        tick();
        v1 = 0;
        tick();
        tick();
        chk("rm_new_t",     32'(t1), 32'h01);
        chk("rm_new_sh",    32'(s1), 32'h01);
        tick();
        chk("rm_new_t0",    32'(t1), 32'h00);
        chk("rm_new_busy",  32'(b1), 32'd0);
        tick();
        tick();
        chk("rm_discard",   32'(s1), 32'h01);

`ifdef TDRV_READBACK_CHECK_EN
        v8 = 1; d8 = 8'h3C;
        tick();
        v8 = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("rb_clean8",    32'(e8), 32'd0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("rb_set",       32'(e8), 32'd1);
        tick();
        tick();
        chk("rb_sticky",    32'(e8), 32'd1);
        chk("rb_clean2",    32'(e2), 32'd0);
        chk("rb_clean1",    32'(e1), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_rst",       32'(e8), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
